// File: rtl/rv_dmem_ctrl.sv
// Data memory for the mini RV core: byte/half/word loads and stores over a
// valid/ready handshake, configurable read latency, one transaction in flight.
module rv_dmem_ctrl #(
  parameter int          WORDS   = 1024,
  parameter logic [31:0] BASE    = 32'h0000_1000,
  parameter int          RD_LAT  = 1,
  parameter bit          PRELOAD = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int          AW    = $clog2(WORDS);
  localparam logic [31:0] INIT0 = PRELOAD ? 32'h4000_0000 : 32'h0;
  localparam logic [31:0] INIT1 = PRELOAD ? 32'h4040_0000 : 32'h0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_rdata;
  logic        r_err;

  // Storage holds data XOR the preload image, so an all-zero power-up
  // array reads back as the preloaded operands without an init process.
  logic [31:0] r_mem [WORDS];

  function automatic logic [31:0] f_init(input logic [AW-1:0] idx);
    logic [31:0] v;
    v = 32'h0;
    if (idx == AW'(0)) v = INIT0;
    if (idx == AW'(1)) v = INIT1;
    return v;
  endfunction

  logic [31:0]   w_off;
  logic [AW-1:0] w_widx;
  logic [1:0]    w_lane;
  logic          w_err;
  logic          w_accept;
  logic [31:0]   w_shift;
  logic [31:0]   w_load;
  logic [3:0]    w_wmask;
  logic [31:0]   w_wimg;

  assign w_off    = i_req_addr - BASE;
  assign w_widx   = w_off[AW+1:2];
  assign w_lane   = w_off[1:0];
  assign w_accept = (r_state == S_IDLE) && i_req_valid;

  // Subtraction wraps for addresses below BASE, so the high-bit test covers both ends.
  assign w_err = (|w_off[31:AW+2])
               | (i_req_size == 2'd3)
               | ((i_req_size == 2'd1) && w_lane[0])
               | ((i_req_size == 2'd2) && (w_lane != 2'd0));

  assign w_shift = (r_mem[w_widx] ^ f_init(w_widx)) >> {w_lane, 3'b000};

  always_comb begin
    w_load = w_shift;
    case (i_req_size)
      2'd0:    w_load = {{24{~i_req_unsigned & w_shift[7]}}, w_shift[7:0]};
      2'd1:    w_load = {{16{~i_req_unsigned & w_shift[15]}}, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  always_comb begin
    w_wmask = 4'b1111;
    case (i_req_size)
      2'd0:    w_wmask = 4'b0001 << w_lane;
      2'd1:    w_wmask = 4'b0011 << w_lane;
      default: w_wmask = 4'b1111;
    endcase
  end

  assign w_wimg = (i_req_wdata << {w_lane, 3'b000}) ^ f_init(w_widx);

  always_ff @(posedge clk) begin
    if (w_accept && i_req_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wmask[i]) r_mem[w_widx][8*i +: 8] <= w_wimg[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (RD_LAT == 1) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = 3'(RD_LAT - 1);
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 3'd1) w_state_nxt = S_RESP;
        else               w_cnt_nxt   = r_cnt - 3'd1;
      end
      S_RESP: begin
        if (i_rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_rdata <= (i_req_we || w_err) ? 32'h0 : w_load;
        r_err   <= w_err;
      end
    end
  end

  assign o_req_ready = (r_state == S_IDLE);
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_rdata = (r_state == S_RESP) ? r_rdata : 32'h0;
  assign o_rsp_err   = (r_state == S_RESP) && r_err;

endmodule

// File: tb/tb_rv_dmem_ctrl.sv
// Bench for rv_dmem_ctrl: RD_LAT=1 and RD_LAT=3 instances share stimulus;
// expected responses are queued per instance and compared as they appear.
module tb_rv_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_unsigned, rsp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        ready1, valid1, err1, ready3, valid3, err3;
  logic [31:0] rdata1, rdata3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc1   = 0;
  int acc3   = 0;
  logic pv1  = 1'b0;
  logic pv3  = 1'b0;

  always #5 clk = ~clk;

  rv_dmem_ctrl #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(ready1), .i_req_we(req_we),
    .i_req_size(req_size), .i_req_unsigned(req_unsigned),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(valid1), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rdata1), .o_rsp_err(err1)
  );

  rv_dmem_ctrl #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(ready3), .i_req_we(req_we),
    .i_req_size(req_size), .i_req_unsigned(req_unsigned),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(valid3), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rdata3), .o_rsp_err(err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && ready1) acc1 <= cyc + 1;
    if (req_valid && ready3) acc3 <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid1) begin
        if (q1.size() == 0) chk("spurious_rsp1", 32'd1, 32'd0);
        else begin
          chk("rdata1", rdata1, q1[0].rdata);
          chk("err1", 32'(err1), 32'(q1[0].err));
          if (rsp_ready) void'(q1.pop_front());
        end
        if (!pv1) chk("lat1", 32'(cyc - acc1 + 1), 32'd1);
      end
      if (valid3) begin
        if (q3.size() == 0) chk("spurious_rsp3", 32'd1, 32'd0);
        else begin
          chk("rdata3", rdata3, q3[0].rdata);
          chk("err3", 32'(err3), 32'(q3[0].err));
          if (rsp_ready) void'(q3.pop_front());
        end
        if (!pv3) chk("lat3", 32'(cyc - acc3 + 1), 32'd3);
      end
      pv1 = valid1;
      pv3 = valid3;
    end else begin
      pv1 = 1'b0;
      pv3 = 1'b0;
    end
  end

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    e.rdata = exp_rd;
    e.err   = exp_err;
    q1.push_back(e);
    q3.push_back(e);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
  endtask

  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input int hold);
    int n;
    if (hold > 0) rsp_ready = 1'b0;
    drive(we, sz, uns, addr, wd, exp_rd, exp_err);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        chk("busy_ready3", 32'(ready3), 32'd0);
        @(negedge clk);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
    end
    n = 0;
    while ((q1.size() != 0 || q3.size() != 0) && n < 30) begin
      @(posedge clk);
      n++;
    end
    if (n >= 30) chk("rsp_timeout", 32'(q1.size() + q3.size()), 32'd0);
    @(negedge clk);
    chk("idle_ready1", 32'(ready1), 32'd1);
    chk("idle_ready3", 32'(ready3), 32'd1);
    chk("idle_valid3", 32'(valid3), 32'd0);
  endtask

  // Reset lands while the RD_LAT=3 instance is still counting down.
  task automatic txn_abort(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_rd);
    drive(we, 2'd2, 1'b0, addr, wd, exp_rd, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_valid3", 32'(valid3), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_valid3", 32'(valid3), 32'd0);
    chk("rst_ready3", 32'(ready3), 32'd1);
    chk("rst_rdata3", rdata3, 32'h0);
    q1.delete();
    q3.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    rsp_ready    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready1", 32'(ready1), 32'd1);
    chk("reset_ready3", 32'(ready3), 32'd1);
    chk("reset_valid1", 32'(valid1), 32'd0);
    chk("reset_valid3", 32'(valid3), 32'd0);
    chk("reset_rdata3", rdata3, 32'h0);
    chk("reset_err3", 32'(err3), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // preload and basic loads
    txn(1'b0, 2'd2, 1'b0, 32'h1004, 32'h0, 32'h4040_0000, 1'b0, 0);
    txn(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'h4000_0000, 1'b0, 0);
    txn(1'b0, 2'd2, 1'b0, 32'h1008, 32'h0, 32'h0000_0000, 1'b0, 0);

    // byte lanes and extension
    txn(1'b1, 2'd2, 1'b0, 32'h1008, 32'h1122_3344, 32'h0, 1'b0, 0);
    txn(1'b1, 2'd0, 1'b0, 32'h1009, 32'h0000_00AB, 32'h0, 1'b0, 0);
    txn(1'b0, 2'd2, 1'b0, 32'h1008, 32'h0, 32'h1122_AB44, 1'b0, 0);
    txn(1'b0, 2'd0, 1'b0, 32'h1009, 32'h0, 32'hFFFF_FFAB, 1'b0, 0);
    txn(1'b0, 2'd0, 1'b1, 32'h1009, 32'h0, 32'h0000_00AB, 1'b0, 0);
    txn(1'b0, 2'd0, 1'b0, 32'h1008, 32'h0, 32'h0000_0044, 1'b0, 0);
    txn(1'b0, 2'd1, 1'b0, 32'h100A, 32'h0, 32'h0000_1122, 1'b0, 0);
    txn(1'b1, 2'd1, 1'b0, 32'h100A, 32'h0000_8001, 32'h0, 1'b0, 0);
    txn(1'b0, 2'd1, 1'b0, 32'h100A, 32'h0, 32'hFFFF_8001, 1'b0, 0);
    txn(1'b0, 2'd1, 1'b1, 32'h100A, 32'h0, 32'h0000_8001, 1'b0, 0);
    txn(1'b0, 2'd2, 1'b0, 32'h1008, 32'h0, 32'h8001_AB44, 1'b0, 0);

    // error cases leave memory untouched
    txn(1'b1, 2'd2, 1'b0, 32'h1002, 32'hDEAD_BEEF, 32'h0, 1'b1, 0);
    txn(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'h4000_0000, 1'b0, 0);
    txn(1'b0, 2'd2, 1'b0, 32'h0FFC, 32'h0, 32'h0, 1'b1, 0);
    txn(1'b0, 2'd2, 1'b0, 32'h2000, 32'h0, 32'h0, 1'b1, 0);
    txn(1'b1, 2'd3, 1'b0, 32'h1004, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    txn(1'b0, 2'd2, 1'b0, 32'h1004, 32'h0, 32'h4040_0000, 1'b0, 0);
    txn(1'b0, 2'd1, 1'b0, 32'h1001, 32'h0, 32'h0, 1'b1, 0);
    txn(1'b1, 2'd0, 1'b0, 32'h2000, 32'h0000_0077, 32'h0, 1'b1, 0);

    // last word in range
    txn(1'b1, 2'd2, 1'b0, 32'h1FFC, 32'h5A5A_A5A5, 32'h0, 1'b0, 0);
    txn(1'b0, 2'd2, 1'b0, 32'h1FFC, 32'h0, 32'h5A5A_A5A5, 1'b0, 0);
    txn(1'b0, 2'd0, 1'b0, 32'h1FFF, 32'h0, 32'h0000_005A, 1'b0, 0);

    // consumer back-pressure
    txn(1'b0, 2'd2, 1'b0, 32'h1008, 32'h0, 32'h8001_AB44, 1'b0, 5);
    txn(1'b0, 2'd0, 1'b0, 32'h100B, 32'h0, 32'hFFFF_FF80, 1'b0, 5);

    // reset mid-operation
    txn_abort(1'b1, 32'h1010, 32'hCAFE_F00D, 32'h0);
    txn_abort(1'b0, 32'h1010, 32'h0, 32'hCAFE_F00D);
    txn(1'b0, 2'd2, 1'b0, 32'h1010, 32'h0, 32'hCAFE_F00D, 1'b0, 0);
    txn(1'b0, 2'd2, 1'b0, 32'h1004, 32'h0, 32'h4040_0000, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
